pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/sat_counter.sv | 36 +++
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register.
//   state_e        : occupancy of the stage (EMPTY / BUSY / FULL)
//   DEFAULT_DATA_W : default payload width (ALU 32 + store 32 + rd 5 + PC+4 32)
//   DEFAULT_CNT_W  : default stall-counter width
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,  // no entries held
    BUSY  = 2'b01,  // main entry only
    FULL  = 2'b10   // main + skid entries
  } state_e;

  localparam int DEFAULT_DATA_W = 101;
  localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, clears count
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Fully registered pipeline stage with a one-entry skid buffer.
// Both in_ready and out_valid decode straight from the state register, so
// no combinational path crosses the stage in either direction.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   flush              : drop all held entries (and this cycle's input)
//   in_valid/in_data   : upstream payload, in_ready tells upstream we accept
//   out_valid/out_data : downstream payload (the main register)
//   out_ready          : downstream accepts this cycle
//   stall_cnt          : saturating count of cycles with out_valid & !out_ready
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // in_ready is 1 here, so in_valid alone is an input handshake.
        if (in_valid && out_ready) begin
          main_d = in_data;
        end else if (out_ready) begin
          state_d = EMPTY;
        end else if (in_valid) begin
          // Downstream stalled: park the new word in the skid entry.
          skid_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        // in_ready is 0 here, so in_data is ignored.
        if (out_ready) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        // Unused encoding: recover to empty.
        state_d = EMPTY;
      end
    endcase

    // Flush wins over every handshake in the same cycle.
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );

endmodule
